// File: rtl/mem_controller.sv
// Burst requester for a single-port synchronous RAM: turns host read/write bursts
// into RAM address/data/write-enable cycles and streams read data back to the host.
module mem_controller #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 4
) (
    input  logic              mem_clk,
    input  logic              mem_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mc_address_mem,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Every host channel uses valid/ready: a transfer happens on a rising edge
    // where both are high; valid never waits on ready, and data is held while
    // valid is high and ready is low.

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_DATA  = 2'd3
    } state_t;

    // state, cur_addr and remaining are the observable FSM context.
    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              last_beat;

    assign last_beat = (remaining == '0);
    assign rd_data   = mem_data_out;

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr  <= req_addr;
                        remaining <= req_len;
                        state     <= req_write ? WRITE : READ_ISSUE;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            cur_addr  <= cur_addr + ADDR_W'(1);
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                READ_ISSUE: begin
                    state <= READ_DATA;
                end
                READ_DATA: begin
                    if (rd_ready) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            cur_addr  <= cur_addr + ADDR_W'(1);
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an in-flight burst stops on the very cycle
    // reset is raised, before the state register has been cleared.
    always_comb begin
        req_ready      = 1'b0;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        rd_last        = 1'b0;
        busy           = 1'b0;
        mem_we         = 1'b0;
        mc_address_mem = '0;
        mem_data_in    = '0;
        if (!mem_reset) begin
            busy           = (state != IDLE);
            mc_address_mem = cur_addr;
            case (state)
                IDLE: req_ready = 1'b1;
                WRITE: begin
                    wr_ready    = 1'b1;
                    mem_we      = wr_valid;
                    mem_data_in = wr_data;
                end
                READ_DATA: begin
                    rd_valid = 1'b1;
                    rd_last  = last_beat;
                    // Prefetch the next word so the RAM output is ready on the next beat.
                    if (rd_ready && !last_beat) begin
                        mc_address_mem = cur_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed plus randomized bench for mem_controller, with a behavioural RAM and a
// word-level reference memory that predicts every burst's contents.
module tb_mem_controller;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 4;

    logic              mem_clk;
    logic              mem_reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic [ADDR_W-1:0] mc_address_mem;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] wq [$];
    logic              vq [$];
    logic              rq [$];

    // Environment RAM: address registered on the edge, write on the same edge.
    logic [DATA_W-1:0] ram [64];
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_init;

    mem_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .mem_clk(mem_clk), .mem_reset(mem_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .mc_address_mem(mc_address_mem), .mem_data_in(mem_data_in),
        .mem_we(mem_we), .mem_data_out(mem_data_out)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_we) begin
            ram[mc_address_mem] <= mem_data_in;
        end
        ram_addr_q <= mc_address_mem;
    end
    assign mem_data_out = ram[ram_addr_q];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a, input int off);
        return ADDR_W'((int'(a) + off) % 64);
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the low clock phase with the controller idle; returns there, idle again.
    task automatic do_write(input logic [ADDR_W-1:0] a, input int len, input int stall, output int cycles);
        int beat;
        logic wv;
        beat = 0;
        cycles = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = LEN_W'(len);
        #1 chk("wr_req_ready", req_ready, 1'b1);
        @(negedge mem_clk);
        req_valid = 1'b0;
        while (beat <= len && cycles < 200) begin
            wv = (vq.size() > 0) ? vq.pop_front() : ($urandom_range(0, 99) >= stall);
            wr_valid = wv;
            wr_data  = (wv && wq.size() > 0) ? wq.pop_front() : $urandom;
            #1;
            chk("wr_busy", busy, 1'b1);
            chk("wr_ready", wr_ready, 1'b1);
            chk("wr_we", mem_we, wv);
            chk("wr_addr", mc_address_mem, wrap_addr(a, beat));
            if (wv) begin
                chk("wr_data", mem_data_in, wr_data);
                ref_mem[wrap_addr(a, beat)] = wr_data;
                beat++;
            end
            @(negedge mem_clk);
            cycles++;
        end
        wr_valid = 1'b0;
        chk("wr_beats", beat, len + 1);
        #1;
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_req_ready", req_ready, 1'b1);
        chk("wr_done_addr", mc_address_mem, wrap_addr(a, len));
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int len, input int stall, output int cycles);
        int got;
        logic rr;
        got = 0;
        cycles = 0;
        exp_q.delete();
        for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[wrap_addr(a, i)]);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = LEN_W'(len);
        #1 chk("rd_req_ready", req_ready, 1'b1);
        @(negedge mem_clk);
        req_valid = 1'b0;
        #1;
        chk("rd_issue_valid", rd_valid, 1'b0);
        chk("rd_issue_busy", busy, 1'b1);
        chk("rd_issue_addr", mc_address_mem, a);
        @(negedge mem_clk);
        while (got <= len && cycles < 200) begin
            rr = (rq.size() > 0) ? rq.pop_front() : ($urandom_range(0, 99) >= stall);
            rd_ready = rr;
            #1;
            chk("rd_valid", rd_valid, 1'b1);
            chk("rd_data", rd_data, exp_q[0]);
            chk("rd_last", rd_last, (got == len));
            if (rr) begin
                void'(exp_q.pop_front());
                got++;
            end
            @(negedge mem_clk);
            cycles++;
        end
        rd_ready = 1'b0;
        chk("rd_beats", got, len + 1);
        #1;
        chk("rd_done_valid", rd_valid, 1'b0);
        chk("rd_done_busy", busy, 1'b0);
        chk("rd_done_addr", mc_address_mem, wrap_addr(a, len));
    endtask

    initial begin
        int n;
        mem_reset = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);

        // Reset state
        @(negedge mem_clk);
        ram_init = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_addr", mc_address_mem, '0);
        @(negedge mem_clk);
        mem_reset = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_addr", mc_address_mem, '0);

        // Single write / read
        @(negedge mem_clk);
        wq.push_back(32'hDEAD_BEEF);
        do_write(6'd5, 0, 0, n);
        @(negedge mem_clk);
        do_read(6'd5, 0, 0, n);
        chk("single_rd_cycles", n, 1);

        // Burst wrapping past the top of memory
        @(negedge mem_clk);
        wq = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(6'd62, 3, 0, n);
        chk("wrap_ram62", ram[62], 32'h11);
        chk("wrap_ram63", ram[63], 32'h22);
        chk("wrap_ram0", ram[0], 32'h33);
        chk("wrap_ram1", ram[1], 32'h44);
        @(negedge mem_clk);
        do_read(6'd62, 3, 0, n);
        chk("wrap_rd_rate", n, 4);

        // Read backpressure
        @(negedge mem_clk);
        rq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_read(6'd0, 3, 0, n);
        chk("bp_cycles", n, 7);

        // Write stalls
        @(negedge mem_clk);
        vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_write(6'd10, 2, 0, n);
        chk("ws_cycles", n, 5);

        // Back-to-back: read request right after the last write beat
        do_write(6'd40, 1, 0, n);
        do_read(6'd40, 1, 0, n);

        // Reset in the middle of a write burst
        @(negedge mem_clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd20; req_len = 4'd7;
        @(negedge mem_clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA000_0000 + 32'(i);
            #1 chk("rst_burst_we", mem_we, 1'b1);
            ref_mem[wrap_addr(6'd20, i)] = wr_data;
            @(negedge mem_clk);
        end
        wr_valid = 1'b1; wr_data = 32'h0BAD_0BAD; mem_reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", mc_address_mem, '0);
        @(negedge mem_clk);
        mem_reset = 1'b0;
        #1;
        chk("after_rst_req_ready", req_ready, 1'b1);
        chk("after_rst_busy", busy, 1'b0);
        chk("after_rst_we", mem_we, 1'b0);
        chk("after_rst_addr", mc_address_mem, '0);
        wr_valid = 1'b0;
        @(negedge mem_clk);
        do_read(6'd20, 7, 20, n);

        // Idle robustness: stray beats with no request
        @(negedge mem_clk);
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_we", mem_we, 1'b0);
            chk("idle_rd_valid", rd_valid, 1'b0);
            chk("idle_req_ready", req_ready, 1'b1);
            @(negedge mem_clk);
        end
        wr_valid = 1'b0; rd_ready = 1'b0;

        // Randomized bursts against the reference memory
        for (int k = 0; k < 30; k++) begin
            logic [ADDR_W-1:0] ra;
            int rl;
            int rs;
            ra = ADDR_W'($urandom_range(0, 63));
            rl = $urandom_range(0, 15);
            rs = $urandom_range(0, 50);
            if ($urandom_range(0, 1) == 1) do_write(ra, rl, rs, n);
            else do_read(ra, rl, rs, n);
            if ($urandom_range(0, 1) == 1) @(negedge mem_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Requester side of the single-port RAM interface: turns host burst read/write requests into `mc_address_mem` / `mem_data_in` / `mem_we` cycles on the 64x32 RAM and returns read data.
- The RAM registers its address on the clock edge and writes on the same edge when `mem_we=1`; `mem_data_out` shows the word at the registered address (new data).
- Sits between the stage's datapath master and the RAM. All host channels use valid/ready handshakes.

Parameters:
- DATA_W, 32, data width (matches RAM word)
- ADDR_W, 6, RAM address width (64 words)
- LEN_W, 4, burst length field; burst = req_len+1 words (1..16)

Ports:
- mem_clk  in  1  single clock, rising edge
- mem_reset  in  1  synchronous reset, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  controller accepts request
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  burst start address
- req_len  in  LEN_W  burst words minus one
- wr_valid  in  1  write beat valid
- wr_ready  out  1  controller accepts write beat
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat valid
- rd_ready  in  1  host accepts read beat
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  final beat of read burst
- busy  out  1  burst in progress (state != IDLE)
- mc_address_mem  out  ADDR_W  RAM address
- mem_data_in  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_data_out  in  DATA_W  RAM read data

Behaviour:
- Clock and reset: one clock `mem_clk`; reset `mem_reset` is synchronous, active-high.
- Reset (during and after the reset edge):
  - state=IDLE, cur_addr=0, beat count=0
  - req_ready=0 while mem_reset=1, else follows state
  - wr_ready=0, rd_valid=0, rd_last=0, mem_we=0, busy=0, mc_address_mem=0, mem_data_in=0
- State machine has four states: IDLE, WRITE, READ_ISSUE, READ_DATA.
- IDLE:
  - req_ready=1, mem_we=0, mc_address_mem=cur_addr.
  - On req_valid: latch cur_addr=req_addr and remaining=req_len.
  - Go to WRITE if req_write=1, else READ_ISSUE.
  - wr_valid and rd_ready are ignored.
- WRITE:
  - wr_ready=1, mc_address_mem=cur_addr, mem_data_in=wr_data, mem_we=wr_valid (combinational).
  - On each wr_valid beat the word is written at that edge. If remaining==0, go to IDLE; else cur_addr+1 and remaining-1.
  - Cycles with wr_valid=0 are stalls: no write, no state change.
- READ_ISSUE:
  - Lasts exactly 1 cycle. mc_address_mem=cur_addr, rd_valid=0.
  - Always goes to READ_DATA, so the RAM has registered the address.
- READ_DATA:
  - rd_valid=1, rd_data=mem_data_out, rd_last=(remaining==0).
  - mc_address_mem = cur_addr+1 when (rd_ready && remaining!=0), else cur_addr. This is a combinational prefetch, giving 1 beat/cycle with no bubble.
  - Without rd_ready the address is held, so rd_data stays stable.
  - On handshake with remaining==0: go to IDLE.
  - On handshake otherwise: cur_addr+1, remaining-1, stay in READ_DATA.
- Latency:
  - First read beat: rd_valid in the 2nd cycle after request acceptance.
  - Write beat: visible in RAM 1 cycle after the accepting edge.
- Address arithmetic is modulo 2^ADDR_W: address 63+1 wraps to 0 within a burst.
- A new request is accepted only in IDLE. A back-to-back request is accepted on the cycle after the last beat.
- Reset during a burst:
  - Burst aborted immediately; no further mem_we pulse.
  - rd_valid/rd_last low on the cycle reset is asserted (combinational gating) and after.
  - Words written before reset remain in RAM.
- The controller never asserts mem_we outside WRITE.

Test Plan:
- Single write/read: write addr=5 len=0 data=0xDEADBEEF, then read addr=5 len=0 → rd_valid 2 cycles after accept, rd_data=0xDEADBEEF, rd_last=1, busy back to 0.
- Burst with wrap: write addr=62 len=3 data 0x11,0x22,0x33,0x44 → RAM[62]=0x11, [63]=0x22, [0]=0x33, [1]=0x44. Read same burst → beats in that order, rd_last only on 0x44, 1 beat/cycle with rd_ready=1.
- Read backpressure: read addr=0 len=3 with rd_ready toggling 1,0,0,1,1,0,1 → rd_data held stable during stalls, exactly 4 beats, no duplicates or skips.
- Write stalls: wr_valid pattern 1,0,1,0,1 for len=2 → mem_we high only on the three valid cycles, addresses consecutive, busy low after the third beat.
- Reset mid-burst: assert mem_reset during beat 2 of a write len=7 → mem_we=0 from that cycle, req_ready=0 during reset then 1. Words 0..1 retained, word 2 onward not written.
- Idle robustness: wr_valid=1 and rd_ready=1 in IDLE with req_valid=0 → mem_we stays 0, rd_valid stays 0, req_ready=1.
